// File: rtl/perceptron_pkg.sv
// Shared FSM state encoding and default widths for the perceptron learner.
package perceptron_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MAC    = 2'd1,
        DECIDE = 2'd2,
        UPDATE = 2'd3
    } state_t;

    localparam int DEF_N_IN   = 7;
    localparam int DEF_W_BITS = 4;

endpackage

// File: rtl/perceptron_wupd.sv
// Single +/-1 weight step. PERCEPTRON_SAT_EN selects saturating steps; otherwise
// the step wraps modulo 2^W_BITS.
module perceptron_wupd
    import perceptron_pkg::*;
#(
    parameter int W_BITS = DEF_W_BITS
) (
    input  logic [W_BITS-1:0] w,
    input  logic              inc,
    output logic [W_BITS-1:0] w_next
);

    localparam logic [W_BITS-1:0] ONE = W_BITS'(1);

    logic [W_BITS-1:0] stepped;

    assign stepped = inc ? (w + ONE) : (w - ONE);

`ifdef PERCEPTRON_SAT_EN
    localparam logic [W_BITS-1:0] W_MAX = {1'b0, {(W_BITS-1){1'b1}}};
    localparam logic [W_BITS-1:0] W_MIN = {1'b1, {(W_BITS-1){1'b0}}};

    always_comb begin
        w_next = stepped;
        if (inc && (w == W_MAX)) begin
            w_next = W_MAX;
        end else if (!inc && (w == W_MIN)) begin
            w_next = W_MIN;
        end
    end
`else
    assign w_next = stepped;
`endif

endmodule

// File: rtl/perceptron_learn.sv
// Serial perceptron: one multiply-free accumulate per input, then decide and
// optionally apply the perceptron rule. Weight step behaviour follows PERCEPTRON_SAT_EN.
module perceptron_learn
    import perceptron_pkg::*;
#(
    parameter int N_IN     = DEF_N_IN,
    parameter int W_BITS   = DEF_W_BITS,
    parameter int ACC_BITS = W_BITS + $clog2(N_IN + 1) + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [N_IN-1:0]          x,
    input  logic                     train,
    input  logic                     target,
    output logic                     busy,
    output logic                     y,
    output logic                     done,
    output logic [7:0]               err_cnt,
    output state_t                   state_dbg,
    output logic [N_IN*W_BITS-1:0]   w_dbg,
    output logic [W_BITS-1:0]        bias_dbg
);

    localparam int IDX_W = $clog2(N_IN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_IN - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    // Handshake: start is taken only in IDLE with busy=0; busy stays high through
    // the done cycle so a start coinciding with done is dropped, never queued.
    state_t                     state;
    logic [W_BITS-1:0]          w      [N_IN];
    logic [W_BITS-1:0]          w_next [N_IN];
    logic [W_BITS-1:0]          bias;
    logic [W_BITS-1:0]          bias_next;
    logic signed [ACC_BITS-1:0] acc;
    logic [IDX_W-1:0]           idx;
    logic [N_IN-1:0]            x_q;
    logic                       train_q;
    logic                       target_q;
    logic                       decision;

    assign decision  = ~acc[ACC_BITS-1];
    assign state_dbg = state;
    assign bias_dbg  = bias;

    genvar g;
    generate
        for (g = 0; g < N_IN; g++) begin : g_wupd
            perceptron_wupd #(.W_BITS(W_BITS)) u_wupd (
                .w      (w[g]),
                .inc    (target_q),
                .w_next (w_next[g])
            );
            assign w_dbg[g*W_BITS +: W_BITS] = w[g];
        end
    endgenerate

    perceptron_wupd #(.W_BITS(W_BITS)) u_bias_upd (
        .w      (bias),
        .inc    (target_q),
        .w_next (bias_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            for (int i = 0; i < N_IN; i++) begin
                w[i] <= '0;
            end
            bias     <= '0;
            acc      <= '0;
            idx      <= '0;
            x_q      <= '0;
            train_q  <= 1'b0;
            target_q <= 1'b0;
            y        <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
            err_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (busy) begin
                        busy <= 1'b0;
                    end else if (start) begin
                        x_q      <= x;
                        train_q  <= train;
                        target_q <= target;
                        acc      <= ACC_BITS'($signed(bias));
                        idx      <= '0;
                        busy     <= 1'b1;
                        state    <= MAC;
                    end
                end
                MAC: begin
                    if (x_q[idx]) begin
                        acc <= acc + ACC_BITS'($signed(w[idx]));
                    end
                    idx <= idx + IDX_ONE;
                    if (idx == IDX_LAST) begin
                        state <= DECIDE;
                    end
                end
                DECIDE: begin
                    y <= decision;
                    if (train_q && (decision != target_q)) begin
                        state <= UPDATE;
                    end else begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                UPDATE: begin
                    for (int i = 0; i < N_IN; i++) begin
                        if (x_q[i]) begin
                            w[i] <= w_next[i];
                        end
                    end
                    bias <= bias_next;
                    if (err_cnt != 8'hFF) begin
                        err_cnt <= err_cnt + 8'd1;
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_perceptron_learn.sv
// Directed bench for perceptron_learn; weight-step expectations follow PERCEPTRON_SAT_EN.
module tb_perceptron_learn;
    import perceptron_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [6:0]   x = '0;
    logic         train = 1'b0;
    logic         target = 1'b0;
    logic         busy;
    logic         y;
    logic         done;
    logic [7:0]   err_cnt;
    state_t       state_dbg;
    logic [27:0]  w_dbg;
    logic [3:0]   bias_dbg;

    logic [3:0]   wu_in = '0;
    logic [3:0]   wu_up;
    logic [3:0]   wu_dn;

    int n_cmp = 0;
    int n_err = 0;

`ifdef PERCEPTRON_SAT_EN
    localparam logic [3:0] UP_OF_7 = 4'h7;
    localparam logic [3:0] DN_OF_8 = 4'h8;
`else
    localparam logic [3:0] UP_OF_7 = 4'h8;
    localparam logic [3:0] DN_OF_8 = 4'h7;
`endif

    always #5 clk = ~clk;

    perceptron_learn dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .x         (x),
        .train     (train),
        .target    (target),
        .busy      (busy),
        .y         (y),
        .done      (done),
        .err_cnt   (err_cnt),
        .state_dbg (state_dbg),
        .w_dbg     (w_dbg),
        .bias_dbg  (bias_dbg)
    );

    perceptron_wupd #(.W_BITS(4)) u_up (.w(wu_in), .inc(1'b1), .w_next(wu_up));
    perceptron_wupd #(.W_BITS(4)) u_dn (.w(wu_in), .inc(1'b0), .w_next(wu_dn));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drives one sample and returns cycles from the accepting edge to done (done cycle inclusive).
    task automatic sample(input logic [6:0] xv, input logic tr, input logic tg, output int cyc);
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        x = xv;
        train = tr;
        target = tg;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int n_done;

        // Reset values
        do_reset();
        #1;
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        check("rst_err", 32'(err_cnt), 32'd0);
        check("rst_w", 32'(w_dbg), 32'd0);

        // Zero input, no training: decision on bias 0 -> y=1
        sample(7'h00, 1'b0, 1'b0, cyc);
        check("t1_lat", 32'(cyc), 32'd9);
        check("t1_y", 32'(y), 32'd1);
        check("t1_err", 32'(err_cnt), 32'd0);

        // Second start two cycles after the first is ignored
        @(negedge clk);
        while (busy) @(negedge clk);
        x = 7'h00; train = 1'b0; target = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("t2_busy", 32'(busy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_done = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        check("t2_done_cnt", 32'(n_done), 32'd1);
        check("t2_idle", 32'(state_dbg), 32'(IDLE));

        // Training mismatch with x=05, target=0
        do_reset();
        sample(7'h05, 1'b1, 1'b0, cyc);
        check("t3_lat", 32'(cyc), 32'd10);
        check("t3_y", 32'(y), 32'd1);
        check("t3_err", 32'(err_cnt), 32'd1);
        check("t3_w", 32'(w_dbg), 32'h000_0F0F);
        check("t3_bias", 32'(bias_dbg), 32'hF);

        // Same sample now classifies as 0 (acc=-3): no update
        sample(7'h05, 1'b1, 1'b0, cyc);
        check("t4_lat", 32'(cyc), 32'd9);
        check("t4_y", 32'(y), 32'd0);
        check("t4_err", 32'(err_cnt), 32'd1);

        // x=0 decides on the negative bias alone
        sample(7'h00, 1'b0, 1'b0, cyc);
        check("t5_lat", 32'(cyc), 32'd9);
        check("t5_y", 32'(y), 32'd0);

        // All ones, target 1: acc=-3 -> update, every weight and bias +1
        sample(7'h7F, 1'b1, 1'b1, cyc);
        check("t6_lat", 32'(cyc), 32'd10);
        check("t6_y", 32'(y), 32'd0);
        check("t6_err", 32'(err_cnt), 32'd2);
        check("t6_w", 32'(w_dbg), 32'h111_1010);
        check("t6_bias", 32'(bias_dbg), 32'h0);

        // No update when prediction matches; start in the done cycle is dropped
        sample(7'h00, 1'b1, 1'b1, cyc);
        check("t7_lat", 32'(cyc), 32'd9);
        check("t7_y", 32'(y), 32'd1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("t7_drop_state", 32'(state_dbg), 32'(IDLE));
        check("t7_drop_busy", 32'(busy), 32'd0);

        // Reset in the middle of MAC
        @(negedge clk);
        x = 7'h7F; train = 1'b1; target = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_state", 32'(state_dbg), 32'(IDLE));
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_y", 32'(y), 32'd0);
        check("mr_err", 32'(err_cnt), 32'd0);
        check("mr_w", 32'(w_dbg), 32'd0);
        check("mr_bias", 32'(bias_dbg), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        check("mr_no_done", 32'(n_done), 32'd0);
        sample(7'h00, 1'b0, 1'b0, cyc);
        check("mr_next_lat", 32'(cyc), 32'd9);
        check("mr_next_y", 32'(y), 32'd1);

        // x=7F target 1 from reset: acc=0 already gives y=1, so nothing changes
        do_reset();
        for (int k = 0; k < 10; k++) begin
            sample(7'h7F, 1'b1, 1'b1, cyc);
        end
        check("ones_lat", 32'(cyc), 32'd9);
        check("ones_err", 32'(err_cnt), 32'd0);
        check("ones_w", 32'(w_dbg), 32'd0);

        // Weight step boundaries
        wu_in = 4'h7;
        #1;
        check("step_up_7", 32'(wu_up), 32'(UP_OF_7));
        check("step_dn_7", 32'(wu_dn), 32'h6);
        wu_in = 4'h8;
        #1;
        check("step_up_8", 32'(wu_up), 32'h9);
        check("step_dn_8", 32'(wu_dn), 32'(DN_OF_8));
        wu_in = 4'hF;
        #1;
        check("step_up_f", 32'(wu_up), 32'h0);
        check("step_dn_f", 32'(wu_dn), 32'hE);

        // 260 forced mismatches on x=0: bias toggles 0/-1, err_cnt saturates
        do_reset();
        for (int k = 0; k < 260; k++) begin
            sample(7'h00, 1'b1, (k % 2 == 1), cyc);
            if (k == 0) check("sat_first_lat", 32'(cyc), 32'd10);
            if (k == 4) check("sat_err_5", 32'(err_cnt), 32'd5);
        end
        check("sat_err", 32'(err_cnt), 32'd255);
        check("sat_bias", 32'(bias_dbg), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
